// File: rtl/reg_file_ab.sv
// reg_file_ab: register file with registered A/B operand latches and write-through bypass
//   CLK      in  clock, all state changes on rising edge
//   Reset_n  in  synchronous active-low reset, clears array, A and B
//   RegWrite in  array write enable
//   WrAddr   in  write index (index 0 writes are dropped)
//   WrData   in  write data
//   RdAddrA  in  read index captured into A
//   RdAddrB  in  read index captured into B
//   LoadAB   in  capture enable for A and B
//   A        out operand latch A
//   B        out operand latch B
module reg_file_ab #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NREGS  = 16
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   input  logic [ADDR_W-1:0] RdAddrA,
   input  logic [ADDR_W-1:0] RdAddrB,
   input  logic              LoadAB,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B
);
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] rd_a, rd_b;
   // same-cycle write to the read index is forwarded so A/B see it at this edge
   always_comb begin
      rd_a = (RdAddrA == '0) ? '0 : (RegWrite && WrAddr == RdAddrA) ? WrData : regs[RdAddrA];
      rd_b = (RdAddrB == '0) ? '0 : (RegWrite && WrAddr == RdAddrB) ? WrData : regs[RdAddrB];
   end
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         A <= '0;
         B <= '0;
      end else begin
         if (RegWrite && WrAddr != '0) regs[WrAddr] <= WrData;
         if (LoadAB) begin
            A <= rd_a;
            B <= rd_b;
         end
      end
   end
endmodule

// File: tb/tb_reg_file_ab.sv
// tb_reg_file_ab: directed and random checks of reg_file_ab against an array model
module tb_reg_file_ab;
   logic        CLK = 0;
   logic        Reset_n = 0;
   logic        RegWrite = 0;
   logic [3:0]  WrAddr = 0;
   logic [15:0] WrData = 0;
   logic [3:0]  RdAddrA = 0;
   logic [3:0]  RdAddrB = 0;
   logic        LoadAB = 0;
   logic [15:0] A, B;
   int total = 0;
   int bad = 0;
   logic [15:0] mdl [16];
   logic [15:0] m_a = 0, m_b = 0;

   reg_file_ab dut (
      .CLK(CLK), .Reset_n(Reset_n), .RegWrite(RegWrite), .WrAddr(WrAddr), .WrData(WrData),
      .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .LoadAB(LoadAB), .A(A), .B(B)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_rd(input int i, input logic we, input int wa, input logic [15:0] wd);
      if (i == 0) return 16'h0;
      if (we && wa == i) return wd;
      return mdl[i];
   endfunction

   // one clock: drive inputs, advance model, compare A/B after the edge
   task automatic cyc(input logic rn, input logic we, input int wa, input logic [15:0] wd,
                      input int ra, input int rb, input logic ld);
      logic [15:0] na, nb;
      Reset_n = rn; RegWrite = we; WrAddr = 4'(wa); WrData = wd;
      RdAddrA = 4'(ra); RdAddrB = 4'(rb); LoadAB = ld;
      na = model_rd(ra, we, wa, wd);
      nb = model_rd(rb, we, wa, wd);
      @(posedge CLK);
      #1;
      if (!rn) begin
         for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
         m_a = 16'h0; m_b = 16'h0;
      end else begin
         if (we && wa != 0) mdl[wa] = wd;
         if (ld) begin m_a = na; m_b = nb; end
      end
      chk("A", A, m_a);
      chk("B", B, m_b);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
      // reset dominates write and load
      cyc(0, 1, 7, 16'hFFFF, 7, 7, 1);
      chk("rst_a", A, 16'h0);
      chk("rst_b", B, 16'h0);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 16'h0, i, 15 - i, 1);
         chk("rst_reg", A, 16'h0);
      end
      // write then read
      cyc(1, 1, 3, 16'hB24D, 0, 0, 0);
      cyc(1, 0, 0, 16'h0, 3, 0, 1);
      chk("wr_rd_a", A, 16'hB24D);
      chk("wr_rd_b", B, 16'h0);
      // bypass, both ports same index
      cyc(1, 1, 5, 16'h9B33, 5, 5, 1);
      chk("byp_a", A, 16'h9B33);
      chk("byp_b", B, 16'h9B33);
      // r0 protection, same cycle and next
      cyc(1, 1, 0, 16'h1234, 0, 5, 1);
      chk("r0_same", A, 16'h0);
      cyc(1, 0, 0, 16'h0, 0, 5, 1);
      chk("r0_next", A, 16'h0);
      // hold while array is written
      cyc(1, 0, 0, 16'h0, 3, 0, 1);
      chk("hold_ld", A, 16'hB24D);
      cyc(1, 1, 3, 16'h0001, 3, 3, 0);
      chk("hold_a", A, 16'hB24D);
      cyc(1, 0, 0, 16'h0, 3, 0, 1);
      chk("hold_rel", A, 16'h0001);
      // fill, then reset mid-run
      for (int i = 1; i < 16; i++) cyc(1, 1, i, 16'(i * 16'h1111), 0, 0, 0);
      cyc(1, 0, 0, 16'h0, 15, 1, 1);
      chk("fill_a", A, 16'hFFFF);
      chk("fill_b", B, 16'h1111);
      cyc(0, 1, 15, 16'hABCD, 15, 15, 1);
      cyc(1, 0, 0, 16'h0, 15, 14, 1);
      chk("mid_rst_a", A, 16'h0);
      chk("mid_rst_b", B, 16'h0);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         int wa, ra, rb;
         wa = $urandom_range(0, 15);
         ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15);
         cyc($urandom_range(0, 29) != 0, 1'($urandom), wa, 16'($urandom), ra, rb, 1'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
